// File: rtl/lsu_sram_ctrl_if.sv
// lsu_sram_ctrl_if: MEM-stage request/response and async SRAM pad signals of the load/store controller
interface lsu_sram_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              i_req;
    logic              i_wren;
    logic [31:0]       i_addr;
    logic [31:0]       i_wdata;
    logic [3:0]        i_bmask;
    logic [31:0]       o_rdata;
    logic              o_sram_stall;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [15:0]       i_sram_dq;
    logic [15:0]       o_sram_dq;
    logic              o_sram_dq_en;
    logic              o_sram_ce_n;
    logic              o_sram_oe_n;
    logic              o_sram_we_n;
    logic              o_sram_lb_n;
    logic              o_sram_ub_n;

    modport slave (
        input  i_req, i_wren, i_addr, i_wdata, i_bmask, i_sram_dq,
        output o_rdata, o_sram_stall, o_sram_addr, o_sram_dq, o_sram_dq_en,
               o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
    );

    modport master (
        output i_req, i_wren, i_addr, i_wdata, i_bmask, i_sram_dq,
        input  o_rdata, o_sram_stall, o_sram_addr, o_sram_dq, o_sram_dq_en,
               o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
    );
endinterface

// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: splits 32-bit loads/stores into two 16-bit async SRAM half-word cycles, stalling the pipeline meanwhile
module lsu_sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input logic            i_clk,
    input logic            i_rst_n,
    lsu_sram_ctrl_if.slave bus
);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lo_q, lo_d, hi_q, hi_d;
    logic          phase, hs, last, ld, unused_addr;

    assign phase = (state_q == LO) || (state_q == HI);
    assign hs    = state_q == HI;
    assign last  = cnt_q == LAST;
    assign ld    = !bus.i_wren;

    // next state, phase counter and load-half capture; inputs are frozen by the stall so no local copy
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_req)
                         state_d = (ld || |bus.i_bmask[1:0]) ? LO : (|bus.i_bmask[3:2] ? HI : DONE);
            LO:      if (last) state_d = (ld || |bus.i_bmask[3:2]) ? HI : DONE;
            HI:      if (last) state_d = DONE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || !phase) ? '0 : cnt_q + 1'b1;
        lo_d  = (state_q == LO && last && ld) ? bus.i_sram_dq : lo_q;
        hi_d  = (state_q == HI && last && ld) ? bus.i_sram_dq : hi_q;
    end

    // state register; a reset aborts any access in flight
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // stall is combinational so it covers the request cycle; it drops in DONE so MEM/WB captures o_rdata
    assign bus.o_sram_stall = i_rst_n && bus.i_req && (state_q != DONE);
    assign bus.o_rdata      = {hi_q, lo_q};
    assign bus.o_sram_addr  = phase ? {bus.i_addr[ADDR_W:2], hs} : '0;
    assign bus.o_sram_ce_n  = !phase;
    assign bus.o_sram_oe_n  = !(phase && ld);
    // write strobe releases in the final phase cycle to give address/data hold
    assign bus.o_sram_we_n  = !(phase && !ld && !last);
    assign bus.o_sram_dq_en = phase && !ld;
    assign bus.o_sram_dq    = bus.o_sram_dq_en ? (hs ? bus.i_wdata[31:16] : bus.i_wdata[15:0]) : '0;
    assign bus.o_sram_lb_n  = !phase || (!ld && !(hs ? bus.i_bmask[2] : bus.i_bmask[0]));
    assign bus.o_sram_ub_n  = !phase || (!ld && !(hs ? bus.i_bmask[3] : bus.i_bmask[1]));
    assign unused_addr      = ^{bus.i_addr[31:ADDR_W+1], bus.i_addr[1:0]};
endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// tb_lsu_sram_ctrl: directed vector table plus hand sequences against a behavioural async SRAM model
module tb_lsu_sram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [15:0] mem [0:255];

    lsu_sram_ctrl_if #(.ADDR_W(18)) bus ();

    lsu_sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(1)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // async SRAM: reads while ce/oe low, byte writes committed at each edge with ce/we low
    assign bus.i_sram_dq = (!bus.o_sram_ce_n && !bus.o_sram_oe_n) ? mem[bus.o_sram_addr[7:0]] : 16'h0;
    always @(posedge clk) begin
        if (!bus.o_sram_ce_n && !bus.o_sram_we_n) begin
            if (!bus.o_sram_lb_n) mem[bus.o_sram_addr[7:0]][7:0] <= bus.o_sram_dq[7:0];
            if (!bus.o_sram_ub_n) mem[bus.o_sram_addr[7:0]][15:8] <= bus.o_sram_dq[15:8];
        end
    end

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        int          stall, ce, oe, we, lb, ub, a_first, a_last;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int ns = 0, nce = 0, noe = 0, nwe = 0, nlb = 0, nub = 0, af = -1, al = -1;
        bit done = 0;
        @(posedge clk);
        #1;
        bus.i_req = 1'b1;
        bus.i_wren = v.wren;
        bus.i_addr = v.addr;
        bus.i_wdata = v.wdata;
        bus.i_bmask = v.bmask;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.o_sram_stall) ns++;
            else begin
                done = 1;
                chk($sformatf("v%0d rdata", idx), bus.o_rdata, v.rdata);
            end
            if (!bus.o_sram_ce_n) begin
                nce++;
                if (af < 0) af = int'(bus.o_sram_addr);
                al = int'(bus.o_sram_addr);
            end
            if (!bus.o_sram_oe_n) noe++;
            if (!bus.o_sram_we_n) nwe++;
            if (!bus.o_sram_lb_n) nlb++;
            if (!bus.o_sram_ub_n) nub++;
        end
        if (!done) chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        chk($sformatf("v%0d stall_cycles", idx), ns, v.stall);
        chk($sformatf("v%0d ce_cycles", idx), nce, v.ce);
        chk($sformatf("v%0d oe_cycles", idx), noe, v.oe);
        chk($sformatf("v%0d we_cycles", idx), nwe, v.we);
        chk($sformatf("v%0d lb_cycles", idx), nlb, v.lb);
        chk($sformatf("v%0d ub_cycles", idx), nub, v.ub);
        chk($sformatf("v%0d addr_first", idx), af, v.a_first);
        chk($sformatf("v%0d addr_last", idx), al, v.a_last);
    endtask

    initial begin
        logic [11:0] b2b_stall;
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
        mem[4] <= 16'h1111;
        mem[5] <= 16'h2222;
        mem[7] <= 16'h9ABC;
        vecs[0] = '{1'b0, 32'h8, 32'h0,         4'h0, 5, 4, 4, 0, 4, 4, 4, 5, 32'h2222_1111};
        vecs[1] = '{1'b1, 32'h4, 32'hAABB_CCDD, 4'hF, 5, 4, 0, 2, 4, 4, 2, 3, 32'h2222_1111};
        vecs[2] = '{1'b0, 32'h4, 32'h0,         4'h0, 5, 4, 4, 0, 4, 4, 2, 3, 32'hAABB_CCDD};
        vecs[3] = '{1'b1, 32'h4, 32'h00EE_0000, 4'h4, 3, 2, 0, 1, 2, 0, 3, 3, 32'hAABB_CCDD};
        vecs[4] = '{1'b0, 32'h4, 32'h0,         4'h0, 5, 4, 4, 0, 4, 4, 2, 3, 32'hAAEE_CCDD};
        vecs[5] = '{1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, 0, 0, 0, -1, -1, 32'hAAEE_CCDD};
        vecs[6] = '{1'b1, 32'hC, 32'h1234_5678, 4'h3, 3, 2, 0, 1, 2, 2, 6, 6, 32'hAAEE_CCDD};
        vecs[7] = '{1'b0, 32'hC, 32'h0,         4'h0, 5, 4, 4, 0, 4, 4, 6, 7, 32'h9ABC_5678};
        vecs[8] = '{1'b0, 32'h8, 32'h0,         4'h0, 5, 4, 4, 0, 4, 4, 4, 5, 32'h2222_1111};

        bus.i_req = 1'b1;
        bus.i_wren = 1'b0;
        bus.i_addr = 32'h8;
        bus.i_wdata = 32'h0;
        bus.i_bmask = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", {31'd0, bus.o_sram_stall}, 32'd0);
        chk("rst ce_n", {31'd0, bus.o_sram_ce_n}, 32'd1);
        chk("rst we_n", {31'd0, bus.o_sram_we_n}, 32'd1);
        chk("rst dq_en", {31'd0, bus.o_sram_dq_en}, 32'd0);
        chk("rst addr", {14'd0, bus.o_sram_addr}, 32'd0);
        chk("rst rdata", bus.o_rdata, 32'd0);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run(i, vecs[i]);
        chk("mem hw2", {16'd0, mem[2]}, 32'hCCDD);
        chk("mem hw3", {16'd0, mem[3]}, 32'hAAEE);
        chk("mem hw6", {16'd0, mem[6]}, 32'h5678);

        b2b_stall = 12'b0111_1101_1111;
        @(posedge clk);
        #1;
        bus.i_req = 1'b1;
        bus.i_wren = 1'b0;
        bus.i_addr = 32'h8;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("b2b stall c%0d", i), {31'd0, bus.o_sram_stall}, {31'd0, b2b_stall[i]});
            if (i == 5) begin
                chk("b2b rdata0", bus.o_rdata, 32'h2222_1111);
                @(posedge clk);
                #1;
                bus.i_addr = 32'hC;
            end
        end
        chk("b2b rdata1", bus.o_rdata, 32'h9ABC_5678);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;

        @(posedge clk);
        #1;
        bus.i_req = 1'b1;
        bus.i_wren = 1'b1;
        bus.i_addr = 32'h10;
        bus.i_wdata = 32'h5555_6666;
        bus.i_bmask = 4'hF;
        repeat (4) @(negedge clk);
        chk("midrst hi addr", {14'd0, bus.o_sram_addr}, 32'h9);
        chk("midrst we low", {31'd0, bus.o_sram_we_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst stall low", {31'd0, bus.o_sram_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst we_n", {31'd0, bus.o_sram_we_n}, 32'd1);
        chk("midrst ce_n", {31'd0, bus.o_sram_ce_n}, 32'd1);
        chk("midrst stall", {31'd0, bus.o_sram_stall}, 32'd0);
        chk("midrst rdata", bus.o_rdata, 32'd0);
        rst_n = 1'b1;
        bus.i_req = 1'b0;
        run(9, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
